regression_seq_ctrl: RTL and testbench
======================================

// Module: regression_seq_ctrl
// PURPOSE
//  Parametrised sequencer for the least-squares regression datapath (sums, means, SSxx/SSxy, B1, B0, error pass).
//  Adds to the fixed-count controller: a run-time sample count, a sample-memory read handshake,
//  a multi-cycle divider handshake, an abort input and a mode that skips the error pass.
//  Sits between the top-level start/ready interface and the regression datapath plus sample RAM.
// PARAMETERS
//  CNT_W        10   sample index / counter width
//  MAX_SAMPLES  150  largest accepted n_samples; must be <= 2**CNT_W-1
// PORTS
//  clk          in   1      single clock; all state changes on rising edge
//  rst          in   1      synchronous, active-low reset
//  start        in   1      begin a run; sampled only in IDLE
//  n_samples    in   CNT_W  sample count, latched on accepted start
//  err_en       in   1      1 = run the error pass; latched on accepted start
//  abort        in   1      return to IDLE on the next edge from any state
//  sample_valid in   1      sample RAM data valid for the current addr
//  div_done     in   1      divider result valid (1-cycle pulse)
//  addr         out  CNT_W  sample RAM address (= counter)
//  mem_rd       out  1      sample RAM read request
//  div_start    out  1      1-cycle divider launch
//  en1, en2     out  1      datapath stage enables (regression / error stage)
//  ctl_init     out  11     {x,y,xbar,ybar,b1,b0,tmp,cnt,E,Xreg,Yreg} clears
//  ctl_ld       out  10     {x,y,xbar,ybar,tmp,b1,b0,E,Xreg,Yreg} loads
//  sel          out  9      datapath mux selects s8..s0
//  ready        out  1      high in IDLE
//  busy         out  1      high outside IDLE and DONE
//  done         out  1      1-cycle pulse in DONE
//  cfg_err      out  1      sticky; set when start is rejected; cleared by an accepted start
// BEHAVIOUR
//  Reset (rst==0 at an edge): state IDLE, counter 0, cfg_err 0, all other outputs 0 except ready=1.
//  Moore outputs, decoded from state only. Exceptions: mem_rd is gated by !sample_valid;
//   default ld_Xreg/ld_Yreg=1 except in DIVX, DIVY, DIVB1 and B0.
//  Start is accepted only when 1 <= n_samples <= MAX_SAMPLES; otherwise stay in IDLE and set cfg_err.
//  States and transitions:
//   IDLE -> INIT1 on accepted start.
//   INIT1: all ctl_init set except Xreg/Yreg -> FETCH1.
//   FETCH1: mem_rd; wait for sample_valid -> SUMX.
//   SUMX: en1, ld_x, sel[2:0]=000 -> SUMY.
//   SUMY: en1, ld_y, s2=1, s1=0, s0=1; counter+1; last -> DIVX, else FETCH1.
//   DIVX: div_start on entry cycle only; hold sel[4:3]=00 until div_done; then ld_xbar -> DIVY.
//   DIVY: as DIVX with sel[4:3]=01 and ld_ybar; init_cnt on exit -> INIT2.
//   INIT2: init x,y -> FETCH2 -> (sample_valid) TEMP -> SSXX -> SSXY.
//   TEMP/SSXX/SSXY: selects identical to the SumX/SumY datapath encoding
//    (TEMP s6s5=00; SSXX s8s7s1=111, s6s5s2s0=0000; SSXY s8..s5,s2,s1=1, s0=0; counter+1).
//   SSXY: last -> DIVB1, else FETCH2.
//   DIVB1: div handshake, sel[4:3]=11, ld_b1 on div_done -> B0.
//   B0: ld_b0, s8s7=00, init_cnt -> ERRF if err_en, else DONE.
//   ERRF: mem_rd; wait for sample_valid -> ERR.
//   ERR: en2, ld_E, counter+1; last -> DONE, else ERRF.
//   DONE: done=1 -> IDLE.
//  "last" means counter == n_samples_latched-1, evaluated before the increment.
//  Counter is CNT_W bits and never wraps, guaranteed by the MAX_SAMPLES check.
//  Protocol rules:
//   - div_done outside a DIV state is ignored.
//   - sample_valid outside FETCH1/FETCH2/ERRF is ignored.
//   - abort has priority over every transition, including start in the same cycle; no done pulse.
//   - rst has priority over abort.
//   - n_samples/err_en changes during a run have no effect.
//   - n_samples==1: every loop makes exactly one pass.
// STRUCTURE
//  Shared package regression_pkg: state encoding (5-bit localparams), ctl_init/ctl_ld bit indices,
//   sel field positions.
//  One sub-module: seq_counter (CNT_W, clear/inc/last compare against the latched count).
//  The FSM, the output decode and the start-acceptance check stay in this module.
// TESTING
//  1. n=4, err_en=1, sample_valid 1 cycle after mem_rd, div_done 3 cycles after div_start
//     -> 4 SUMX/SUMY pairs, 3 div_start pulses, 4 ERR cycles, one done pulse, ready back high.
//  2. n=1, err_en=0 -> one pass per loop, no ERR state, done 1 cycle after B0.
//  3. start with n=0, then n=151 -> state stays IDLE, cfg_err=1;
//     then n=2 -> run proceeds and cfg_err clears.
//  4. abort asserted during DIVY while div_done arrives the same cycle
//     -> IDLE next edge, ld_ybar never asserted, no done.
//  5. rst=0 mid-SSXY with abort=1 -> all outputs at reset values, counter 0;
//     then start with n=3 completes normally.
//  6. sample_valid held low 10 cycles in FETCH2 -> mem_rd held, no ld_* pulses, counter unchanged.

Source files
------------

// File: rtl/regression_pkg.sv
// rtl/regression_pkg.sv - state encoding and control-word layout for the regression sequencer
package regression_pkg;

    typedef enum logic [4:0] {
        S_IDLE   = 5'd0,
        S_INIT1  = 5'd1,
        S_FETCH1 = 5'd2,
        S_SUMX   = 5'd3,
        S_SUMY   = 5'd4,
        S_DIVX   = 5'd5,
        S_DIVY   = 5'd6,
        S_INIT2  = 5'd7,
        S_FETCH2 = 5'd8,
        S_TEMP   = 5'd9,
        S_SSXX   = 5'd10,
        S_SSXY   = 5'd11,
        S_DIVB1  = 5'd12,
        S_B0     = 5'd13,
        S_ERRF   = 5'd14,
        S_ERR    = 5'd15,
        S_DONE   = 5'd16
    } state_t;

    localparam int INIT_W = 11;
    localparam int LD_W   = 10;
    localparam int SEL_W  = 9;

    // ctl_init = {x,y,xbar,ybar,b1,b0,tmp,cnt,E,Xreg,Yreg}
    localparam int INIT_X    = 10;
    localparam int INIT_Y    = 9;
    localparam int INIT_XBAR = 8;
    localparam int INIT_YBAR = 7;
    localparam int INIT_B1   = 6;
    localparam int INIT_B0   = 5;
    localparam int INIT_TMP  = 4;
    localparam int INIT_CNT  = 3;
    localparam int INIT_E    = 2;

    // ctl_ld = {x,y,xbar,ybar,tmp,b1,b0,E,Xreg,Yreg}
    localparam int LD_X    = 9;
    localparam int LD_Y    = 8;
    localparam int LD_XBAR = 7;
    localparam int LD_YBAR = 6;
    localparam int LD_TMP  = 5;
    localparam int LD_B1   = 4;
    localparam int LD_B0   = 3;
    localparam int LD_E    = 2;
    localparam int LD_XREG = 1;
    localparam int LD_YREG = 0;

    // sel = s8..s0
    localparam logic [SEL_W-1:0] SEL_NONE  = 9'b000000000;
    localparam logic [SEL_W-1:0] SEL_SUMY  = 9'b000000101;
    localparam logic [SEL_W-1:0] SEL_DIVY  = 9'b000001000;
    localparam logic [SEL_W-1:0] SEL_DIVB1 = 9'b000011000;
    localparam logic [SEL_W-1:0] SEL_SSXX  = 9'b110000010;
    localparam logic [SEL_W-1:0] SEL_SSXY  = 9'b111100110;

    function automatic logic is_div(input state_t s);
        return (s == S_DIVX) || (s == S_DIVY) || (s == S_DIVB1);
    endfunction

endpackage

// File: rtl/seq_counter.sv
// rtl/seq_counter.sv - sample index counter with last-sample compare against the latched count
module seq_counter #(
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic [CNT_W-1:0] n_lat_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             last_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == (n_lat_i - CNT_W'(1)));

endmodule

// File: rtl/regression_seq_ctrl.sv
// rtl/regression_seq_ctrl.sv - sequencer for the least-squares regression datapath and sample RAM
module regression_seq_ctrl
    import regression_pkg::*;
#(
    parameter int CNT_W       = 10,
    parameter int MAX_SAMPLES = 150
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  n_samples,
    input  logic              err_en,
    input  logic              abort,
    input  logic              sample_valid,
    input  logic              div_done,
    output logic [CNT_W-1:0]  addr,
    output logic              mem_rd,
    output logic              div_start,
    output logic              en1,
    output logic              en2,
    output logic [INIT_W-1:0] ctl_init,
    output logic [LD_W-1:0]   ctl_ld,
    output logic [SEL_W-1:0]  sel,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] n_lat_q;
    logic             err_en_q;
    logic             cfg_err_q;
    logic             div_start_q;

    logic             start_ok;
    logic             cnt_last;
    logic             cnt_inc;
    logic             cnt_clr;
    logic             div_fire;

    assign start_ok = (n_samples != '0) && (n_samples <= CNT_W'(MAX_SAMPLES));
    // A divider result arriving together with abort must not be loaded.
    assign div_fire = div_done && !abort;

    seq_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (cnt_clr),
        .inc_i   (cnt_inc && !abort),
        .n_lat_i (n_lat_q),
        .cnt_o   (addr),
        .last_o  (cnt_last)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start && start_ok) state_d = S_INIT1;
            S_INIT1:  state_d = S_FETCH1;
            S_FETCH1: if (sample_valid) state_d = S_SUMX;
            S_SUMX:   state_d = S_SUMY;
            S_SUMY:   state_d = cnt_last ? S_DIVX : S_FETCH1;
            S_DIVX:   if (div_done) state_d = S_DIVY;
            S_DIVY:   if (div_done) state_d = S_INIT2;
            S_INIT2:  state_d = S_FETCH2;
            S_FETCH2: if (sample_valid) state_d = S_TEMP;
            S_TEMP:   state_d = S_SSXX;
            S_SSXX:   state_d = S_SSXY;
            S_SSXY:   state_d = cnt_last ? S_DIVB1 : S_FETCH2;
            S_DIVB1:  if (div_done) state_d = S_B0;
            S_B0:     state_d = err_en_q ? S_ERRF : S_DONE;
            S_ERRF:   if (sample_valid) state_d = S_ERR;
            S_ERR:    state_d = cnt_last ? S_DONE : S_ERRF;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            n_lat_q     <= '0;
            err_en_q    <= 1'b0;
            cfg_err_q   <= 1'b0;
            div_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            // Launch the divider once, on the first cycle of each divide state.
            div_start_q <= is_div(state_d) && (state_d != state_q);
            if ((state_q == S_IDLE) && start && !abort) begin
                if (start_ok) begin
                    n_lat_q   <= n_samples;
                    err_en_q  <= err_en;
                    cfg_err_q <= 1'b0;
                end else begin
                    cfg_err_q <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        mem_rd   = 1'b0;
        en1      = 1'b0;
        en2      = 1'b0;
        ctl_init = '0;
        ctl_ld   = '0;
        sel      = SEL_NONE;
        ready    = 1'b0;
        done     = 1'b0;
        cnt_inc  = 1'b0;
        case (state_q)
            S_IDLE: ready = 1'b1;
            S_INIT1: begin
                ctl_init[INIT_X]    = 1'b1;
                ctl_init[INIT_Y]    = 1'b1;
                ctl_init[INIT_XBAR] = 1'b1;
                ctl_init[INIT_YBAR] = 1'b1;
                ctl_init[INIT_B1]   = 1'b1;
                ctl_init[INIT_B0]   = 1'b1;
                ctl_init[INIT_TMP]  = 1'b1;
                ctl_init[INIT_CNT]  = 1'b1;
                ctl_init[INIT_E]    = 1'b1;
            end
            S_FETCH1, S_FETCH2, S_ERRF: mem_rd = !sample_valid;
            S_SUMX: begin
                en1        = 1'b1;
                ctl_ld[LD_X] = 1'b1;
            end
            S_SUMY: begin
                en1          = 1'b1;
                ctl_ld[LD_Y] = 1'b1;
                sel          = SEL_SUMY;
                cnt_inc      = 1'b1;
            end
            S_DIVX: ctl_ld[LD_XBAR] = div_fire;
            S_DIVY: begin
                sel                = SEL_DIVY;
                ctl_ld[LD_YBAR]    = div_fire;
                ctl_init[INIT_CNT] = div_fire;
            end
            S_INIT2: begin
                ctl_init[INIT_X] = 1'b1;
                ctl_init[INIT_Y] = 1'b1;
            end
            S_TEMP: begin
                en1            = 1'b1;
                ctl_ld[LD_TMP] = 1'b1;
            end
            S_SSXX: begin
                en1          = 1'b1;
                ctl_ld[LD_X] = 1'b1;
                sel          = SEL_SSXX;
            end
            S_SSXY: begin
                en1          = 1'b1;
                ctl_ld[LD_Y] = 1'b1;
                sel          = SEL_SSXY;
                cnt_inc      = 1'b1;
            end
            S_DIVB1: begin
                sel           = SEL_DIVB1;
                ctl_ld[LD_B1] = div_fire;
            end
            S_B0: begin
                ctl_ld[LD_B0]      = 1'b1;
                ctl_init[INIT_CNT] = 1'b1;
            end
            S_ERR: begin
                en2          = 1'b1;
                ctl_ld[LD_E] = 1'b1;
                cnt_inc      = 1'b1;
            end
            S_DONE: done = 1'b1;
            default: ;
        endcase
        // X/Y operand registers track the RAM outside idle and the divide/B0 steps.
        if (!((state_q == S_IDLE) || is_div(state_q) || (state_q == S_B0))) begin
            ctl_ld[LD_XREG] = 1'b1;
            ctl_ld[LD_YREG] = 1'b1;
        end
    end

    assign cnt_clr   = ctl_init[INIT_CNT] || abort || (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign cfg_err   = cfg_err_q;
    assign div_start = div_start_q;

endmodule

// File: tb/tb_regression_seq_ctrl.sv
// tb/tb_regression_seq_ctrl.sv - directed self-checking bench for regression_seq_ctrl
module tb_regression_seq_ctrl;
    import regression_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  n_samples;
    logic        err_en;
    logic        abort;
    logic        sample_valid;
    logic        div_done;
    logic [9:0]  addr;
    logic        mem_rd;
    logic        div_start;
    logic        en1;
    logic        en2;
    logic [10:0] ctl_init;
    logic [9:0]  ctl_ld;
    logic [8:0]  sel;
    logic        ready;
    logic        busy;
    logic        done;
    logic        cfg_err;

    int checks = 0;
    int errors = 0;

    logic prev_mem_rd;
    int   cd;
    int   idx;
    int   n_sumx, sumx_addr, n_sumy, n_ssxy, n_div, n_err, n_done, done_idx, b0_idx, n_ybar, n_idle;
    logic timeout;

    regression_seq_ctrl #(.CNT_W(10), .MAX_SAMPLES(150)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .n_samples    (n_samples),
        .err_en       (err_en),
        .abort        (abort),
        .sample_valid (sample_valid),
        .div_done     (div_done),
        .addr         (addr),
        .mem_rd       (mem_rd),
        .div_start    (div_start),
        .en1          (en1),
        .en2          (en2),
        .ctl_init     (ctl_init),
        .ctl_ld       (ctl_ld),
        .sel          (sel),
        .ready        (ready),
        .busy         (busy),
        .done         (done),
        .cfg_err      (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic do_start(input logic [9:0] n, input logic e);
        @(posedge clk);
        #1;
        start = 1'b1; n_samples = n; err_en = e; abort = 1'b0;
        sample_valid = 1'b0; div_done = 1'b0;
        idx = 0; prev_mem_rd = 1'b0; cd = 0; timeout = 1'b0;
        n_sumx = 0; sumx_addr = 0; n_sumy = 0; n_ssxy = 0; n_div = 0; n_err = 0;
        n_done = 0; done_idx = -1; b0_idx = -1; n_ybar = 0; n_idle = 0;
    endtask

    // RAM answers one cycle after a read request; divider answers 3 cycles after launch.
    // mode 0: until done; 1: stop on DIVY entry; 2: stop at SSXY with addr 1; 3: stop at FETCH2 with addr 1
    task automatic run_env(input int mode, input int max_cycles);
        logic seen_init2;
        seen_init2 = 1'b0;
        for (int k = 0; k < max_cycles; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            idx++;
            if (idx == 2) begin
                n_samples = 10'd9;
                err_en = ~err_en;
            end
            sample_valid = prev_mem_rd;
            div_done = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) div_done = 1'b1;
            end
            #1;
            prev_mem_rd = mem_rd;
            if (div_start) begin
                cd = 3;
                n_div++;
            end
            if (en1 && ctl_ld[LD_X] && sel == SEL_NONE) begin
                n_sumx++;
                sumx_addr += int'(addr);
            end
            if (ctl_ld[LD_Y] && sel == SEL_SUMY) n_sumy++;
            if (ctl_ld[LD_Y] && sel == SEL_SSXY) n_ssxy++;
            if (en2) n_err++;
            if (ctl_ld[LD_B0]) b0_idx = idx;
            if (ctl_ld[LD_YBAR]) n_ybar++;
            if (!busy && !done) n_idle++;
            if (ctl_init == 11'b11000000000) seen_init2 = 1'b1;
            if (done) begin
                n_done++;
                done_idx = idx;
            end
            if (mode == 0 && done) return;
            if (mode == 1 && sel == SEL_DIVY && div_start) return;
            if (mode == 2 && sel == SEL_SSXY && addr == 10'd1) return;
            if (mode == 3 && seen_init2 && mem_rd && addr == 10'd1) return;
        end
        timeout = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b0; start = 1'b0; n_samples = '0; err_en = 1'b0; abort = 1'b1;
        sample_valid = 1'b0; div_done = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        abort = 1'b0; div_done = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready); end
        checks++;
        if ({mem_rd, div_start, en1, en2, busy, done, cfg_err} !== 7'b0) begin
            errors++; $display("FAIL reset_flags: got %b want 0000000", {mem_rd, div_start, en1, en2, busy, done, cfg_err});
        end
        checks++;
        if ({ctl_init, ctl_ld, sel} !== 30'b0) begin
            errors++; $display("FAIL reset_ctl: got init=%b ld=%b sel=%b want zeros", ctl_init, ctl_ld, sel);
        end
        checks++;
        if (addr !== 10'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", addr); end
        rst = 1'b1;
    endtask

    task automatic test_full_run;
        do_start(10'd4, 1'b1);
        run_env(0, 200);
        @(posedge clk); #1; sample_valid = 1'b0; div_done = 1'b0; #1;
        checks++;
        if (timeout !== 1'b0) begin errors++; $display("FAIL full_timeout: got %b want 0", timeout); end
        checks++;
        if (n_sumx != 4 || n_sumy != 4 || n_ssxy != 4) begin
            errors++; $display("FAIL full_passes: got sumx=%0d sumy=%0d ssxy=%0d want 4/4/4", n_sumx, n_sumy, n_ssxy);
        end
        checks++;
        if (sumx_addr != 6) begin errors++; $display("FAIL full_addr_sum: got %0d want 6", sumx_addr); end
        checks++;
        if (n_div != 3) begin errors++; $display("FAIL full_div_starts: got %0d want 3", n_div); end
        checks++;
        if (n_err != 4) begin errors++; $display("FAIL full_err_cycles: got %0d want 4", n_err); end
        checks++;
        if (n_done != 1 || done_idx != 64) begin
            errors++; $display("FAIL full_done: got count=%0d cycle=%0d want 1 at 64", n_done, done_idx);
        end
        checks++;
        if (n_idle != 0) begin errors++; $display("FAIL full_busy: got %0d non-busy cycles want 0", n_idle); end
        checks++;
        if ({ready, busy} !== 2'b10) begin errors++; $display("FAIL full_ready_after: got %b want 10", {ready, busy}); end
    endtask

    task automatic test_single_sample;
        do_start(10'd1, 1'b0);
        run_env(0, 200);
        checks++;
        if (n_sumx != 1 || n_ssxy != 1) begin
            errors++; $display("FAIL single_passes: got sumx=%0d ssxy=%0d want 1/1", n_sumx, n_ssxy);
        end
        checks++;
        if (n_div != 3 || n_err != 0) begin
            errors++; $display("FAIL single_div_err: got div=%0d err=%0d want 3/0", n_div, n_err);
        end
        checks++;
        if (n_done != 1 || done_idx != 25 || (done_idx - b0_idx) != 1) begin
            errors++; $display("FAIL single_done: got count=%0d cycle=%0d b0=%0d want 1 at 25 b0 24", n_done, done_idx, b0_idx);
        end
    endtask

    task automatic test_cfg_err;
        @(posedge clk); #1;
        start = 1'b1; n_samples = 10'd0; err_en = 1'b0;
        @(posedge clk); #1; start = 1'b0; #1;
        checks++;
        if ({cfg_err, ready, busy} !== 3'b110) begin errors++; $display("FAIL cfg_n0: got %b want 110", {cfg_err, ready, busy}); end
        start = 1'b1; n_samples = 10'd151;
        @(posedge clk); #1; start = 1'b0; #1;
        checks++;
        if ({cfg_err, ready, busy} !== 3'b110) begin errors++; $display("FAIL cfg_n151: got %b want 110", {cfg_err, ready, busy}); end
        start = 1'b1; n_samples = 10'd150;
        @(posedge clk); #1; start = 1'b0; #1;
        checks++;
        if ({cfg_err, ready, busy} !== 3'b001) begin errors++; $display("FAIL cfg_n150: got %b want 001", {cfg_err, ready, busy}); end
        abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0; #1;
        start = 1'b1; n_samples = 10'd0;
        @(posedge clk); #1; start = 1'b0; #1;
        checks++;
        if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_resticky: got %b want 1", cfg_err); end
        do_start(10'd2, 1'b0);
        run_env(0, 200);
        checks++;
        if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_cleared: got %b want 0", cfg_err); end
        checks++;
        if (n_sumx != 2 || n_done != 1 || done_idx != 34) begin
            errors++; $display("FAIL cfg_run: got sumx=%0d done=%0d at %0d want 2/1 at 34", n_sumx, n_done, done_idx);
        end
    endtask

    task automatic test_abort_divy;
        int n_d;
        int not_ready;
        do_start(10'd2, 1'b1);
        run_env(1, 200);
        checks++;
        if (timeout !== 1'b0) begin errors++; $display("FAIL abort_reach_divy: got timeout %b want 0", timeout); end
        repeat (2) begin
            @(posedge clk); #1; sample_valid = 1'b0; div_done = 1'b0;
        end
        @(posedge clk); #1; div_done = 1'b1; abort = 1'b1; #1;
        checks++;
        if ({sel == SEL_DIVY, ctl_ld[LD_YBAR], ctl_init[INIT_CNT]} !== 3'b100) begin
            errors++; $display("FAIL abort_ybar: got divy=%b ld_ybar=%b init_cnt=%b want 1/0/0", sel == SEL_DIVY, ctl_ld[LD_YBAR], ctl_init[INIT_CNT]);
        end
        @(posedge clk); #1; div_done = 1'b0; abort = 1'b0; #1;
        checks++;
        if ({ready, busy, done, addr} !== {3'b100, 10'd0}) begin
            errors++; $display("FAIL abort_idle: got ready=%b busy=%b done=%b addr=%0d want 1/0/0/0", ready, busy, done, addr);
        end
        n_d = 0; not_ready = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #2;
            if (done) n_d++;
            if (!ready) not_ready++;
        end
        checks++;
        if (n_d != 0 || not_ready != 0 || n_ybar != 0) begin
            errors++; $display("FAIL abort_quiet: got done=%0d notready=%0d ybar=%0d want 0/0/0", n_d, not_ready, n_ybar);
        end
        start = 1'b1; n_samples = 10'd2; abort = 1'b1;
        @(posedge clk); #1; start = 1'b0; abort = 1'b0; #1;
        checks++;
        if ({ready, busy} !== 2'b10) begin errors++; $display("FAIL abort_over_start: got %b want 10", {ready, busy}); end
    endtask

    task automatic test_reset_mid;
        do_start(10'd3, 1'b1);
        run_env(2, 200);
        checks++;
        if (timeout !== 1'b0) begin errors++; $display("FAIL rstmid_reach_ssxy: got timeout %b want 0", timeout); end
        rst = 1'b0; abort = 1'b1;
        @(posedge clk); #1; #1;
        checks++;
        if ({ready, mem_rd, div_start, en1, en2, busy, done, cfg_err} !== 8'b10000000 || addr !== 10'd0) begin
            errors++; $display("FAIL rstmid_flags: got %b addr=%0d want 10000000 addr=0", {ready, mem_rd, div_start, en1, en2, busy, done, cfg_err}, addr);
        end
        checks++;
        if ({ctl_init, ctl_ld, sel} !== 30'b0) begin
            errors++; $display("FAIL rstmid_ctl: got init=%b ld=%b sel=%b want zeros", ctl_init, ctl_ld, sel);
        end
        rst = 1'b1; abort = 1'b0;
        do_start(10'd3, 1'b1);
        run_env(0, 300);
        checks++;
        if (n_sumx != 3 || n_err != 3 || n_done != 1 || done_idx != 52) begin
            errors++; $display("FAIL rstmid_rerun: got sumx=%0d err=%0d done=%0d at %0d want 3/3/1 at 52", n_sumx, n_err, n_done, done_idx);
        end
    endtask

    task automatic test_fetch_stall;
        int bad;
        do_start(10'd2, 1'b0);
        run_env(3, 200);
        checks++;
        if (timeout !== 1'b0 || addr !== 10'd1) begin
            errors++; $display("FAIL stall_reach_fetch2: got timeout=%b addr=%0d want 0/1", timeout, addr);
        end
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1; sample_valid = 1'b0; div_done = 1'b0; idx++; #1;
            if (mem_rd !== 1'b1 || ctl_ld[9:2] !== 8'b0 || addr !== 10'd1 || en1 !== 1'b0) bad++;
            prev_mem_rd = mem_rd;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL stall_hold: got %0d bad cycles want 0", bad); end
        run_env(0, 200);
        checks++;
        if (timeout !== 1'b0 || n_ssxy != 2 || n_done != 1 || done_idx != 44) begin
            errors++; $display("FAIL stall_resume: got timeout=%b ssxy=%0d done=%0d at %0d want 0/2/1 at 44", timeout, n_ssxy, n_done, done_idx);
        end
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_single_sample();
        test_cfg_err();
        test_abort_divy();
        test_reset_mid();
        test_fetch_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
